sequential_regdec_left: RTL and testbench

SEQUENTIAL_REGDEC_LEFT -- requirements
Module: sequential_regdec_left

---
 rtl/regdec_pkg.sv | 10 +
 rtl/regdec_left_stage.sv | 28 ++
 rtl/sequential_regdec_left.sv | 54 +++++
 tb/tb_sequential_regdec_left.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/regdec_pkg.sv
// Shared defaults for the registered barrel-shifter family (left and right variants).
package regdec_pkg;

    // Data bus width in bits.
    localparam int REGDEC_WIDTH     = 8;

    // Shift-amount width; always enough bits to encode 0..WIDTH-1.
    localparam int REGDEC_SEL_WIDTH = $clog2(REGDEC_WIDTH);

endpackage : regdec_pkg

// File: rtl/regdec_left_stage.sv
// One stage of the log2 left barrel shifter.
// When en_i is set, the word moves left by SHIFT positions. The SHIFT vacated
// LSBs take fill_i. When en_i is clear, the word passes through unchanged.
module regdec_left_stage #(
    parameter int WIDTH = 8,
    parameter int SHIFT = 1
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             en_i,
    input  logic             fill_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] fill_bits;

    // The vacated low bits are filled with copies of fill_i. All higher bits are zero.
    assign fill_bits = {{(WIDTH - SHIFT){1'b0}}, {SHIFT{fill_i}}};

    // Either pass the word through, or shift it and OR in the fill pattern.
    // NOTE: data_o gets a default on entry so that no path leaves it unassigned and infers a latch.
    always_comb begin
        data_o = data_i;
        if (en_i) begin
            data_o = (data_i << SHIFT) | fill_bits;
        end
    end

endmodule : regdec_left_stage

// File: rtl/sequential_regdec_left.sv
// Registered left barrel shifter.
// A combinational chain of SEL_WIDTH stages feeds the single output register.
// Stage k shifts by 2^k when sequenceur[k] is set and fills the vacated bits with masse.
// Bits shifted past the MSB are discarded. The result depends only on the inputs
// sampled at the current edge and never on the previous value of bus_out.
module sequential_regdec_left
    import regdec_pkg::*;
#(
    parameter int WIDTH     = REGDEC_WIDTH,
    parameter int SEL_WIDTH = REGDEC_SEL_WIDTH
) (
    input  logic [SEL_WIDTH-1:0] sequenceur,
    input  logic [WIDTH-1:0]     bus_in,
    input  logic                 masse,
    input  logic                 clk,
    input  logic                 reset,
    output logic [WIDTH-1:0]     bus_out
);

    // stage_data[0] holds the raw input.
    // stage_data[k+1] holds the output of stage k.
    logic [SEL_WIDTH:0][WIDTH-1:0] stage_data;
    logic [WIDTH-1:0]              bus_out_d;
    logic [WIDTH-1:0]              bus_out_q;

    assign stage_data[0] = bus_in;

    for (genvar k = 0; k < SEL_WIDTH; k++) begin : g_stage
        regdec_left_stage #(
            .WIDTH (WIDTH),
            .SHIFT (1 << k)
        ) u_stage (
            .data_i (stage_data[k]),
            .en_i   (sequenceur[k]),
            .fill_i (masse),
            .data_o (stage_data[k+1])
        );
    end

    assign bus_out_d = stage_data[SEL_WIDTH];

    // Output register: a synchronous reset clears it and takes priority over the load.
    // NOTE: non-blocking assignment keeps every flop sampling pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_out_q <= '0;
        end else begin
            bus_out_q <= bus_out_d;
        end
    end

    assign bus_out = bus_out_q;

endmodule : sequential_regdec_left

// File: tb/tb_sequential_regdec_left.sv
// Self-checking bench for sequential_regdec_left.
// The reference model computes the shifted word with plain integer arithmetic.
// A negedge compare process checks bus_out against that model on every cycle.
// Directed literal checks pin the model to known values.
module tb_sequential_regdec_left;

    localparam int W = 8;
    localparam int S = 3;

    logic [S-1:0] sequenceur;
    logic [W-1:0] bus_in;
    logic         masse;
    logic         clk;
    logic         reset;
    logic [W-1:0] bus_out;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] model_q;
    logic         model_valid = 1'b0;

    sequential_regdec_left dut (
        .sequenceur (sequenceur),
        .bus_in     (bus_in),
        .masse      (masse),
        .clk        (clk),
        .reset      (reset),
        .bus_out    (bus_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: multiply by 2^s, add 2^s-1 when filling with ones, keep the low W bits.
    function automatic logic [W-1:0] ref_shift(input int b, input int s, input bit m);
        longint full;
        full = longint'(b) * (longint'(1) << s);
        if (m) full = full + ((longint'(1) << s) - 1);
        return W'(full % (longint'(1) << W));
    endfunction

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: bus_out=%0d expected=%0d at %0t", name, got, exp, $time);
        end
    endtask

    // Model register: it tracks what bus_out must hold after each rising edge.
    always @(posedge clk) begin
        if (reset === 1'b1) begin
            model_q     <= '0;
            model_valid <= 1'b1;
        end else if (model_valid) begin
            model_q <= ref_shift(int'(bus_in), int'(sequenceur), masse);
        end
    end

    // Compare on every falling edge, well away from the active edge.
    always @(negedge clk) begin
        if (model_valid) check("model", bus_out, model_q);
    end

    // Set the inputs now, then let one rising edge load them, ending at the next falling edge.
    task automatic apply(input bit r, input int s, input int b, input bit m);
        reset      = r;
        sequenceur = S'(s);
        bus_in     = W'(b);
        masse      = m;
        @(negedge clk);
    endtask

    initial begin
        // Reset with arbitrary inputs present.
        apply(1'b1, 5, 8'hA5, 1'b1);
        check("reset_state", bus_out, 8'd0);

        // Sweep of shift amounts with zero fill.
        apply(1'b0, 0, 127, 1'b0); check("sweep_s0", bus_out, 8'd127);
        apply(1'b0, 1, 127, 1'b0); check("sweep_s1", bus_out, 8'd254);
        apply(1'b0, 2, 127, 1'b0); check("sweep_s2", bus_out, 8'd252);
        apply(1'b0, 3, 127, 1'b0); check("sweep_s3", bus_out, 8'd248);

        // Fill with ones, and the maximum shift amount.
        apply(1'b0, 2, 127, 1'b1); check("fill_s2",    bus_out, 8'd255);
        apply(1'b0, 7, 1,   1'b1); check("fill_s7_m1", bus_out, 8'd255);
        apply(1'b0, 7, 1,   1'b0); check("fill_s7_m0", bus_out, 8'd128);

        // Raising reset between edges must not change bus_out; the next edge clears it.
        reset = 1'b1;
        #2;
        check("reset_no_edge", bus_out, 8'd128);
        @(negedge clk);
        check("reset_edge", bus_out, 8'd0);

        // Reset has priority over a load on the same edge.
        apply(1'b0, 3, 8'h0F, 1'b0);
        apply(1'b1, 0, 255, 1'b0); check("prio_reset", bus_out, 8'd0);
        apply(1'b0, 0, 255, 1'b0); check("prio_load",  bus_out, 8'd255);

        // Input changes between edges must not disturb bus_out.
        reset      = 1'b0;
        sequenceur = 3'd1;
        bus_in     = 8'd3;
        masse      = 1'b0;
        @(posedge clk);
        #1;
        sequenceur = 3'd4;
        bus_in     = 8'd9;
        masse      = 1'b1;
        #2;
        check("hold_mid", bus_out, 8'd6);
        @(negedge clk);
        check("hold_negedge", bus_out, 8'd6);
        @(negedge clk);
        check("hold_next_edge", bus_out, 8'd159);

        // Results must not accumulate: the same inputs on consecutive edges give the same value.
        apply(1'b0, 1, 8'h81, 1'b0); check("no_accum_a", bus_out, 8'h02);
        apply(1'b0, 1, 8'h81, 1'b0); check("no_accum_b", bus_out, 8'h02);

        // Every shift amount and fill value with random data, plus occasional resets.
        for (int s = 0; s < 8; s++) begin
            for (int m = 0; m < 2; m++) begin
                for (int k = 0; k < 12; k++) begin
                    apply(1'b0, s, int'($urandom_range(0, 255)), bit'(m));
                end
            end
        end
        for (int k = 0; k < 200; k++) begin
            apply(($urandom_range(0, 15) == 0), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 255)), bit'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_sequential_regdec_left
